// File: rtl/apb_exe2_pkg.sv
// rtl/apb_exe2_pkg.sv - register offsets, STATUS bit indices and FSM states for exe unit 2 APB slave
package apb_exe2_pkg;

    localparam logic [3:0] OFF_ARG_A  = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_RESULT = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int STAT_DONE  = 0;
    localparam int STAT_ERROR = 1;
    localparam int STAT_BUSY  = 2;

    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } exe_state_t;

endpackage

// File: rtl/apb_exe2_seq.sv
// rtl/apb_exe2_seq.sv - run sequencer: latency counter, result/error capture, DONE/BUSY status
module apb_exe2_seq
    import apb_exe2_pkg::*;
#(
    parameter int BITS    = 4,
    parameter int LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [BITS-1:0] i_exe_result,
    input  logic            i_exe_error,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_error,
    output logic            o_sample,
    output logic [BITS-1:0] o_result
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    exe_state_t       r_state;
    exe_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_error;
    logic [BITS-1:0]  r_result;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state: leave IDLE on a start, return once the counter has run out
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_next = ST_RUN;
            ST_RUN:  if (r_cnt == '0) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter load/decrement and capture of the datapath outputs at the sampling edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= LAT_M1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == '0) begin
                        r_result <= i_exe_result;
                        r_error  <= i_exe_error;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_busy   = (r_state == ST_RUN);
    assign o_sample = (r_state == ST_RUN) && (r_cnt == '0);
    assign o_done   = r_done;
    assign o_error  = r_error;
    assign o_result = r_result;

endmodule

// File: rtl/apb_exe_unit_2_slave.sv
// rtl/apb_exe_unit_2_slave.sv - APB front-end for exe unit 2; APB_EXE2_PSLVERR_EN enables error responses
module apb_exe_unit_2_slave
    import apb_exe2_pkg::*;
#(
    parameter int BITS    = 4,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [3:0]        i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic [DATA_W-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [BITS-1:0]   o_exe_argA,
    input  logic [BITS-1:0]   i_exe_result,
    input  logic              i_exe_error
);

    logic [BITS-1:0] r_arg_a;
    logic            w_busy;
    logic            w_done;
    logic            w_error;
    logic            w_sample;
    logic [BITS-1:0] w_result;

    logic w_access;
    logic w_sel_arg;
    logic w_sel_ctrl;
    logic w_sel_result;
    logic w_sel_status;
    logic w_result_stall;
    logic w_pready;
    logic w_wr;
    logic w_arg_wr;
    logic w_start;

    // Upper write-data bits have no destination
    logic w_unused_pwdata;
    assign w_unused_pwdata = ^i_pwdata[DATA_W-1:BITS];

    assign w_access     = i_psel & i_penable;
    assign w_sel_arg    = (i_paddr == OFF_ARG_A);
    assign w_sel_ctrl   = (i_paddr == OFF_CTRL);
    assign w_sel_result = (i_paddr == OFF_RESULT);
    assign w_sel_status = (i_paddr == OFF_STATUS);

    // A RESULT read during a run waits for the sampling cycle, where it is forwarded
    assign w_result_stall = w_sel_result & ~i_pwrite & w_busy & ~w_sample;
    assign w_pready       = w_access & ~w_result_stall;
    assign o_pready       = w_pready;

    // Operand and START are locked out while busy so the operand stays stable
    assign w_wr     = w_access & i_pwrite & w_pready;
    assign w_arg_wr = w_wr & w_sel_arg & ~w_busy;
    assign w_start  = w_wr & w_sel_ctrl & i_pwdata[0] & ~w_busy;

`ifdef APB_EXE2_PSLVERR_EN
    logic w_err;
    assign w_err = (i_paddr[1:0] != 2'b00)
                 | (i_pwrite & (w_sel_result | w_sel_status))
                 | (~i_pwrite & w_sel_ctrl)
                 | (i_pwrite & w_busy & (w_sel_arg | (w_sel_ctrl & i_pwdata[0])));
    assign o_pslverr = w_pready & w_err;
`else
    assign o_pslverr = 1'b0;
`endif

    // Operand register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_arg_a <= '0;
        else if (w_arg_wr) r_arg_a <= i_pwdata[BITS-1:0];
    end

    assign o_exe_argA = r_arg_a;

    apb_exe2_seq #(
        .BITS    (BITS),
        .LATENCY (LATENCY)
    ) u_seq (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (w_start),
        .i_exe_result (i_exe_result),
        .i_exe_error  (i_exe_error),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_error      (w_error),
        .o_sample     (w_sample),
        .o_result     (w_result)
    );

    // Read mux; unaligned, write-only and unmapped addresses read as zero
    always_comb begin
        o_prdata = '0;
        if (i_psel & ~i_pwrite) begin
            if (w_sel_arg) begin
                o_prdata[BITS-1:0] = r_arg_a;
            end else if (w_sel_result) begin
                o_prdata[BITS-1:0] = w_sample ? i_exe_result : w_result;
            end else if (w_sel_status) begin
                o_prdata[STAT_DONE]  = w_done;
                o_prdata[STAT_ERROR] = w_error;
                o_prdata[STAT_BUSY]  = w_busy;
            end
        end
    end

endmodule

// File: tb/tb_apb_exe_unit_2_slave.sv
// tb/tb_apb_exe_unit_2_slave.sv - directed self-checking bench for apb_exe_unit_2_slave
module tb_apb_exe_unit_2_slave;

    localparam int BITS    = 4;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 2;

`ifdef APB_EXE2_PSLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              psel, penable, pwrite;
    logic [3:0]        paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr;
    logic [BITS-1:0]   exe_argA;
    logic [BITS-1:0]   exe_result;
    logic              exe_error;

    int n_checks = 0;
    int n_fail   = 0;

    apb_exe_unit_2_slave #(
        .BITS    (BITS),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_psel       (psel),
        .i_penable    (penable),
        .i_pwrite     (pwrite),
        .i_paddr      (paddr),
        .i_pwdata     (pwdata),
        .o_prdata     (prdata),
        .o_pready     (pready),
        .o_pslverr    (pslverr),
        .o_exe_argA   (exe_argA),
        .i_exe_result (exe_result),
        .i_exe_error  (exe_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Bus tasks start 1 time unit after a rising edge and return likewise
    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
        int  k;
        bit  fin;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        err = 1'b0; k = 0; fin = 0;
        while (!fin) begin
            #4;
            if (pready === 1'b1) begin
                err = pslverr; fin = 1;
            end else if (k >= 20) begin
                n_checks++; n_fail++;
                $display("FAIL write_timeout addr=%h got pready=%b want 1", a, pready);
                fin = 1;
            end else begin
                k++;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err, output int waits);
        bit fin;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        d = '0; err = 1'b0; waits = 0; fin = 0;
        while (!fin) begin
            #4;
            if (pready === 1'b1) begin
                d = prdata; err = pslverr; fin = 1;
            end else if (waits >= 20) begin
                n_checks++; n_fail++;
                $display("FAIL read_timeout addr=%h got pready=%b want 1", a, pready);
                fin = 1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e; int w;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        exe_result = '0; exe_error = 1'b0;
        #2;
        n_checks++; if (exe_argA !== 4'h0) begin n_fail++; $display("FAIL reset_argA got %h want 0", exe_argA); end
        n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got %h want 0", prdata); end
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got %b want 0", pready); end
        n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        apb_write(4'h0, 32'h9, e);
        n_checks++; if (exe_argA !== 4'h9) begin n_fail++; $display("FAIL pre_reset_argA got %h want 9", exe_argA); end
        #3; rst = 1'b1; #1;
        n_checks++; if (exe_argA !== 4'h0) begin n_fail++; $display("FAIL async_reset_argA got %h want 0", exe_argA); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", d); end
        apb_read(4'h0, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_argA_read got %h want 0", d); end
    endtask

    task automatic test_main_run();
        logic [31:0] d; logic e; int w;
        exe_result = 4'h7; exe_error = 1'b0;
        apb_write(4'h0, 32'hFFFF_FFF9, e);
        n_checks++; if (exe_argA !== 4'h9) begin n_fail++; $display("FAIL main_argA got %h want 9", exe_argA); end
        apb_write(4'h4, 32'h1, e);
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL main_start_err got %b want 0", e); end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'hC;
        #4;
        n_checks++; if (prdata !== 32'h4) begin n_fail++; $display("FAIL main_status_c1 got %h want 4", prdata); end
        @(posedge clk); #5;
        n_checks++; if (prdata !== 32'h4) begin n_fail++; $display("FAIL main_status_c2 got %h want 4", prdata); end
        @(posedge clk); #5;
        n_checks++; if (prdata !== 32'h1) begin n_fail++; $display("FAIL main_status_done got %h want 1", prdata); end
        @(posedge clk); #1;
        psel = 1'b0;
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h7) begin n_fail++; $display("FAIL main_result got %h want 7", d); end
        n_checks++; if (w !== 0) begin n_fail++; $display("FAIL main_result_waits got %0d want 0", w); end
    endtask

    task automatic test_error_flag();
        logic [31:0] d; logic e; int w;
        exe_result = 4'hF; exe_error = 1'b1;
        apb_write(4'h4, 32'h1, e);
        repeat (4) @(posedge clk);
        #1;
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL err_status got %h want 3", d); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'hF) begin n_fail++; $display("FAIL err_result got %h want f", d); end
    endtask

    task automatic test_result_stall();
        logic [31:0] d; logic e; int w;
        exe_result = 4'h7; exe_error = 1'b0;
        apb_write(4'h4, 32'h1, e);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h8;
        #4;
        n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL stall_pready got %b want 0", pready); end
        @(posedge clk); #5;
        n_checks++; if (pready !== 1'b1) begin n_fail++; $display("FAIL stall_release_pready got %b want 1", pready); end
        n_checks++; if (prdata !== 32'h7) begin n_fail++; $display("FAIL stall_forward got %h want 7", prdata); end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL stall_status got %h want 1", d); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h7) begin n_fail++; $display("FAIL stall_result got %h want 7", d); end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d; logic e; int w;
        exe_result = 4'h5; exe_error = 1'b0;
        apb_write(4'h4, 32'h1, e);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h1;
        #4;
        n_checks++; if (pslverr !== EXP_ERR) begin n_fail++; $display("FAIL busy_arg_pslverr got %b want %b", pslverr, EXP_ERR); end
        @(posedge clk); #1;
        paddr = 4'h4; pwdata = 32'h1;
        #4;
        n_checks++; if (pslverr !== EXP_ERR) begin n_fail++; $display("FAIL busy_start_pslverr got %b want %b", pslverr, EXP_ERR); end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        n_checks++; if (exe_argA !== 4'h9) begin n_fail++; $display("FAIL busy_argA got %h want 9", exe_argA); end
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL busy_single_completion got %h want 1", d); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL busy_result got %h want 5", d); end
    endtask

    task automatic test_decode();
        logic [31:0] d; logic e; int w;
        apb_read(4'h4, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ctrl_read got %h want 0", d); end
        n_checks++; if (e !== EXP_ERR) begin n_fail++; $display("FAIL ctrl_read_err got %b want %b", e, EXP_ERR); end
        apb_read(4'h2, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL unaligned_read got %h want 0", d); end
        n_checks++; if (e !== EXP_ERR) begin n_fail++; $display("FAIL unaligned_err got %b want %b", e, EXP_ERR); end
        apb_write(4'h8, 32'hA, e);
        n_checks++; if (e !== EXP_ERR) begin n_fail++; $display("FAIL result_write_err got %b want %b", e, EXP_ERR); end
        apb_write(4'h1, 32'h3, e);
        n_checks++; if (exe_argA !== 4'h9) begin n_fail++; $display("FAIL unaligned_write_argA got %h want 9", exe_argA); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL result_after_write got %h want 5", d); end
    endtask

    task automatic test_reset_in_run();
        logic [31:0] d; logic e; int w;
        exe_result = 4'hC; exe_error = 1'b1;
        apb_write(4'h4, 32'h1, e);
        #4; rst = 1'b1; #1;
        n_checks++; if (exe_argA !== 4'h0) begin n_fail++; $display("FAIL run_reset_argA got %h want 0", exe_argA); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL run_reset_status got %h want 0", d); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL run_reset_result got %h want 0", d); end
        exe_result = 4'h6; exe_error = 1'b0;
        apb_write(4'h4, 32'h1, e);
        repeat (3) @(posedge clk);
        #1;
        apb_read(4'hC, d, e, w);
        n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL restart_status got %h want 1", d); end
        apb_read(4'h8, d, e, w);
        n_checks++; if (d !== 32'h6) begin n_fail++; $display("FAIL restart_result got %h want 6", d); end
    endtask

    initial begin
        test_reset();
        test_main_run();
        test_error_flag();
        test_result_stall();
        test_busy_writes();
        test_decode();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
